// File: rtl/cpu_out_pkg.sv
// Shared types and constants for the CPU result sink.
// Serializer states and the default word geometry.
package cpu_out_pkg;

    typedef enum logic {
        IDLE,
        SEND
    } sink_state_t;

    localparam int DEF_WIDTH      = 32;
    localparam int BYTES_PER_WORD = DEF_WIDTH / 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers.
// Head word is presented combinationally on rdata_o.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wptr_q;
    logic [PW:0]      rptr_q;

    // Pointer registers; the extra top bit tells full from empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage array; no reset needed since pointers gate visibility.
    always_ff @(posedge clock) begin
        if (push_i) mem[wptr_q[PW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem[rptr_q[PW-1:0]];
    assign level_o = wptr_q - rptr_q;
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PW] != rptr_q[PW]) &&
                     (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

endmodule

// File: rtl/cpu_out_sink.sv
// CPU result sink: buffers flagged words and streams them
// out LSB-first as bytes, counting words lost to a full FIFO.
module cpu_out_sink
    import cpu_out_pkg::*;
#(
    parameter int WIDTH    = 8 * BYTES_PER_WORD,
    parameter int DEPTH    = 8,
    parameter int CNTWIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    outFlag,
    input  logic [WIDTH-1:0]        out,
    input  logic                    byteReady,
    output logic                    byteValid,
    output logic [7:0]              byteData,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    output logic [CNTWIDTH-1:0]     dropCount,
    input  logic                    clearOverflow
);

    localparam int BPW = WIDTH / 8;
    localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

    sink_state_t          state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [BPW-1:0][7:0]  shift_q, shift_d;
    logic                 ovf_q, ovf_d;
    logic [CNTWIDTH-1:0]  drop_q, drop_d;

    logic                 f_push;
    logic                 f_pop;
    logic [WIDTH-1:0]     f_data;
    logic                 last;
    logic                 drop;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (f_push),
        .pop_i   (f_pop),
        .wdata_i (out),
        .rdata_o (f_data),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    assign last = (idx_q == IW'(BPW - 1));

    // A full FIFO still accepts a word if a slot frees on the same edge.
    assign f_push = outFlag && (!full || f_pop);
    assign drop   = outFlag && !f_push;

    // Serializer next state: load head when idle or after the last byte.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        f_pop   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    f_pop   = 1'b1;
                    shift_d = f_data;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (byteReady) begin
                    if (!last) begin
                        idx_d = idx_q + 1'b1;
                    end else if (!empty) begin
                        f_pop   = 1'b1;
                        shift_d = f_data;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    // Drop bookkeeping; a drop wins over a coincident clear.
    always_comb begin
        ovf_d  = ovf_q | drop;
        drop_d = drop_q;
        if (clearOverflow) begin
            ovf_d  = drop;
            drop_d = drop ? CNTWIDTH'(1) : '0;
        end else if (drop && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // State, shifter and drop counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    assign byteValid = (state_q == SEND);
    assign byteData  = shift_q[idx_q];
    assign overflow  = ovf_q;
    assign dropCount = drop_q;

endmodule

// File: tb/tb_cpu_out_sink.sv
// Scoreboard bench for cpu_out_sink: expected bytes are queued
// at stimulus time and checked by a monitor on each accepted byte.
module tb_cpu_out_sink;

    logic        clock = 1'b0;
    logic        reset;
    logic        outFlag;
    logic [31:0] out;
    logic        byteReady;
    logic        byteValid;
    logic [7:0]  byteData;
    logic [3:0]  level;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [15:0] dropCount;
    logic        clearOverflow;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    cpu_out_sink dut (
        .clock         (clock),
        .reset         (reset),
        .outFlag       (outFlag),
        .out           (out),
        .byteReady     (byteReady),
        .byteValid     (byteValid),
        .byteData      (byteData),
        .level         (level),
        .full          (full),
        .empty         (empty),
        .overflow      (overflow),
        .dropCount     (dropCount),
        .clearOverflow (clearOverflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one outFlag cycle; queue its bytes if it should be kept.
    task automatic pulse(input logic [31:0] w, input bit keep);
        outFlag = 1'b1;
        out     = w;
        if (keep)
            for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
        @(posedge clock);
        #1;
        outFlag = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (!byteValid && empty) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: drain timeout, got busy expected idle", nm);
        end
    endtask

    // Monitor: every byte the host accepts must match the queue head.
    always @(negedge clock) begin
        if (!reset && byteValid && byteReady) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL byte: got %h expected none", byteData);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (byteData !== e) begin
                    errors++;
                    $display("FAIL byte: got %h expected %h", byteData, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        outFlag       = 1'b0;
        out           = '0;
        byteReady     = 1'b0;
        clearOverflow = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst valid", byteValid, 0);
        chk("rst data", byteData, 0);
        chk("rst level", level, 0);
        chk("rst full", full, 0);
        chk("rst empty", empty, 1);
        chk("rst ovf", overflow, 0);
        chk("rst drops", dropCount, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // 1: single word, latency and back-to-back bytes
        byteReady = 1'b1;
        pulse(32'hA1B2C3D4, 1);
        chk("t1 valid k", byteValid, 0);
        chk("t1 level k", level, 1);
        @(posedge clock);
        #1;
        chk("t1 valid k+1", byteValid, 1);
        chk("t1 byte0", byteData, 8'hD4);
        chk("t1 level k+1", level, 0);
        repeat (4) @(posedge clock);
        #1;
        chk("t1 valid end", byteValid, 0);
        chk("t1 empty end", empty, 1);

        // 2: stall mid-word
        pulse(32'h11223344, 1);
        @(posedge clock);
        @(posedge clock);
        #1;
        byteReady = 1'b0;
        repeat (5) begin
            @(negedge clock);
            chk("t2 hold valid", byteValid, 1);
            chk("t2 hold data", byteData, 8'h33);
        end
        @(posedge clock);
        #1;
        byteReady = 1'b1;
        wait_idle("t2 drain");

        // 3: burst of 12 into a stalled sink
        byteReady = 1'b0;
        for (int i = 0; i < 12; i++)
            pulse(32'h0000_0100 + i, i < 9);
        chk("t3 level", level, 8);
        chk("t3 full", full, 1);
        chk("t3 drops", dropCount, 3);
        chk("t3 ovf", overflow, 1);

        // 4: last byte accepted on the same edge as a new word
        byteReady = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        pulse(32'hDEADBEEF, 1);
        chk("t4 level", level, 8);
        chk("t4 drops", dropCount, 3);
        chk("t4 full", full, 1);
        wait_idle("t3/t4 drain");

        // 6: clear coincident with a drop, then clear alone
        byteReady = 1'b0;
        for (int i = 0; i < 9; i++)
            pulse(32'h5500_0000 + i, 1);
        clearOverflow = 1'b1;
        pulse(32'hFFFF_0000, 0);
        chk("t6 ovf", overflow, 1);
        chk("t6 drops", dropCount, 1);
        @(posedge clock);
        #1;
        clearOverflow = 1'b0;
        chk("t6 ovf clr", overflow, 0);
        chk("t6 drops clr", dropCount, 0);
        byteReady = 1'b1;
        wait_idle("t6 drain");

        // 5: async reset at idx=2
        pulse(32'hCAFEBABE, 1);
        pulse(32'h13579BDF, 1);
        @(posedge clock);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("t5 valid", byteValid, 0);
        chk("t5 level", level, 0);
        chk("t5 empty", empty, 1);
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        pulse(32'h0F1E2D3C, 1);
        @(posedge clock);
        #1;
        chk("t5 byte0", byteData, 8'h3C);
        wait_idle("t5 drain");

        chk("queue drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
